// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: owns the C64 bus via DMA and moves bytes between the C64 bus and
// the SDRAM controller, returning per-byte advance strobes and end/fault events.
module reu_dma_seq #(
    parameter int unsigned START_WAIT = 1
) (
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       BA,
    input  logic [7:0] CD,
    output logic       DMAn,
    output logic       BusRW,
    output logic       BusDrive,
    output logic [7:0] CDOut,
    output logic       RAMReq,
    output logic       RAMWE,
    output logic [7:0] RAMWrD,
    input  logic [7:0] RAMRdD,
    input  logic       RAMRdy,
    output logic       IncCA,
    output logic       IncREUA,
    output logic       DecLen,
    output logic       XferEnd,
    output logic       SetEndOfBlock,
    output logic       SetVerifyErr,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_C_RD, S_R_RD, S_R_WR, S_C_WR, S_NEXT, S_END
    } state_t;

    typedef enum logic [1:0] {
        X_STASH, X_FETCH, X_SWAP, X_VERIFY
    } xfer_t;

    state_t     r_state;
    xfer_t      r_type;
    logic [2:0] r_wait;
    logic [7:0] r_cbyte;
    logic [7:0] r_rbyte;
    logic       r_vmis;
    state_t     w_first;

    always_comb begin
        w_first = (r_type == X_FETCH) ? S_R_RD : S_C_RD;
    end

    always_ff @(negedge PHI2) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_type  <= X_STASH;
            r_wait  <= '0;
            r_cbyte <= '0;
            r_rbyte <= '0;
            r_vmis  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Execute) begin
                        r_type  <= xfer_t'(XferType);
                        r_wait  <= '0;
                        r_vmis  <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_wait == 3'(START_WAIT - 1)) r_state <= w_first;
                    else                              r_wait  <= r_wait + 3'd1;
                end
                S_C_RD: begin
                    if (BA) begin
                        r_cbyte <= CD;
                        r_state <= (r_type == X_STASH) ? S_R_WR : S_R_RD;
                    end
                end
                S_R_RD: begin
                    if (RAMRdy) begin
                        r_rbyte <= RAMRdD;
                        // compare against the fresh SDRAM byte; held until NEXT decides
                        r_vmis  <= (r_type == X_VERIFY) && (r_cbyte != RAMRdD);
                        case (r_type)
                            X_FETCH: r_state <= S_C_WR;
                            X_SWAP:  r_state <= S_R_WR;
                            default: r_state <= S_NEXT;
                        endcase
                    end
                end
                S_R_WR: begin
                    if (RAMRdy) r_state <= (r_type == X_SWAP) ? S_C_WR : S_NEXT;
                end
                S_C_WR: begin
                    if (BA) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (Length1 || r_vmis) r_state <= S_END;
                    else                   r_state <= w_first;
                end
                S_END:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus drive follows BA within the C_WR cycle so a VIC stall never sees a write.
    always_comb begin
        DMAn          = (r_state == S_IDLE);
        Busy          = (r_state != S_IDLE);
        BusDrive      = (r_state == S_C_WR) && BA;
        BusRW         = !BusDrive;
        CDOut         = r_rbyte;
        RAMReq        = (r_state == S_R_RD) || (r_state == S_R_WR);
        RAMWE         = (r_state == S_R_WR);
        RAMWrD        = r_cbyte;
        IncCA         = (r_state == S_NEXT);
        IncREUA       = (r_state == S_NEXT);
        DecLen        = (r_state == S_NEXT);
        SetEndOfBlock = (r_state == S_NEXT) && Length1;
        SetVerifyErr  = (r_state == S_NEXT) && r_vmis;
        XferEnd       = (r_state == S_NEXT) && (Length1 || r_vmis);
    end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed bench for reu_dma_seq: stash, fetch with BA stall, swap, verify mismatch,
// reset mid-transfer and Execute handling, with hand-computed expectations.
module tb_reu_dma_seq;

    logic       PHI2 = 1'b0;
    logic       Reset = 1'b1;
    logic       Execute = 1'b0;
    logic [1:0] XferType = 2'b00;
    logic       Length1 = 1'b0;
    logic       BA = 1'b1;
    logic [7:0] CD = 8'h00;
    logic       DMAn, BusRW, BusDrive, RAMReq, RAMWE;
    logic [7:0] CDOut, RAMWrD;
    logic [7:0] RAMRdD = 8'h00;
    logic       RAMRdy = 1'b0;
    logic       IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy;

    int n_chk = 0;
    int n_pass = 0;
    int n_ca = 0, n_reua = 0, n_dl = 0, n_xe = 0, n_eob = 0, n_ve = 0;
    int s_ca, s_reua, s_dl, s_xe, s_eob, s_ve;

    reu_dma_seq #(.START_WAIT(1)) dut (
        .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .XferType(XferType),
        .Length1(Length1), .BA(BA), .CD(CD), .DMAn(DMAn), .BusRW(BusRW),
        .BusDrive(BusDrive), .CDOut(CDOut), .RAMReq(RAMReq), .RAMWE(RAMWE),
        .RAMWrD(RAMWrD), .RAMRdD(RAMRdD), .RAMRdy(RAMRdy), .IncCA(IncCA),
        .IncREUA(IncREUA), .DecLen(DecLen), .XferEnd(XferEnd),
        .SetEndOfBlock(SetEndOfBlock), .SetVerifyErr(SetVerifyErr), .Busy(Busy)
    );

    always #5 PHI2 = ~PHI2;

    // pulse counters sampled on the edge opposite to the DUT's active edge
    always @(posedge PHI2) begin
        if (IncCA)         n_ca   <= n_ca + 1;
        if (IncREUA)       n_reua <= n_reua + 1;
        if (DecLen)        n_dl   <= n_dl + 1;
        if (XferEnd)       n_xe   <= n_xe + 1;
        if (SetEndOfBlock) n_eob  <= n_eob + 1;
        if (SetVerifyErr)  n_ve   <= n_ve + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge PHI2);
        #1;
    endtask

    task automatic snap();
        s_ca = n_ca; s_reua = n_reua; s_dl = n_dl;
        s_xe = n_xe; s_eob = n_eob; s_ve = n_ve;
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_dman", DMAn, 1); chk("rst_busrw", BusRW, 1);
        chk("rst_busy", Busy, 0); chk("rst_ramreq", RAMReq, 0);
        chk("rst_drive", BusDrive, 0); chk("rst_xend", XferEnd, 0);
        Reset = 1'b0;
        cyc();

        // 1: stash two bytes, RAMRdy one cycle late each byte
        snap();
        XferType = 2'b00; Execute = 1'b1; CD = 8'h5A;
        cyc(); Execute = 1'b0; #1;
        chk("t1_start_dman", DMAn, 0); chk("t1_start_busy", Busy, 1);
        cyc(); chk("t1_crd_ramreq", RAMReq, 0);
        cyc(); chk("t1_rwr_req", RAMReq, 1); chk("t1_rwr_we", RAMWE, 1);
        chk("t1_wrd0", RAMWrD, 8'h5A);
        cyc(); chk("t1_rwr_hold", RAMReq, 1);
        RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; CD = 8'hA5; #1;
        chk("t1_next0_ca", IncCA, 1); chk("t1_next0_xend", XferEnd, 0);
        cyc(); chk("t1_crd1_ca", IncCA, 0);
        cyc(); chk("t1_wrd1", RAMWrD, 8'hA5); chk("t1_rwr1_we", RAMWE, 1);
        cyc(); RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; Length1 = 1'b1; #1;
        chk("t1_next1_xend", XferEnd, 1); chk("t1_next1_eob", SetEndOfBlock, 1);
        chk("t1_next1_verr", SetVerifyErr, 0);
        cyc(); Length1 = 1'b0; #1;
        chk("t1_end_dman", DMAn, 0); chk("t1_end_xend", XferEnd, 0);
        cyc(); chk("t1_idle_dman", DMAn, 1); chk("t1_idle_busy", Busy, 0);
        chk("t1_n_ca", n_ca - s_ca, 2); chk("t1_n_dl", n_dl - s_dl, 2);
        chk("t1_n_xe", n_xe - s_xe, 1);

        // 2: fetch one byte, BA low for three cycles in C_WR
        snap();
        XferType = 2'b01; Length1 = 1'b1; Execute = 1'b1;
        cyc(); Execute = 1'b0;
        cyc(); chk("t2_rrd_req", RAMReq, 1); chk("t2_rrd_we", RAMWE, 0);
        RAMRdD = 8'h3C; RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BA = 1'b0; #1;
            chk("t2_stall_drive", BusDrive, 0); chk("t2_stall_rw", BusRW, 1);
            chk("t2_stall_ca", IncCA, 0);
            cyc();
        end
        BA = 1'b1; #1;
        chk("t2_drive", BusDrive, 1); chk("t2_rw", BusRW, 0); chk("t2_cdout", CDOut, 8'h3C);
        cyc(); chk("t2_next_ca", IncCA, 1); chk("t2_next_drive", BusDrive, 0);
        cyc(); cyc();
        chk("t2_idle", Busy, 0); chk("t2_n_ca", n_ca - s_ca, 1);

        // 3: swap one byte
        snap();
        XferType = 2'b10; Length1 = 1'b1; CD = 8'h11; RAMRdD = 8'h22; Execute = 1'b1;
        cyc(); Execute = 1'b0;
        cyc(); chk("t3_crd_req", RAMReq, 0);
        cyc(); chk("t3_rrd_req", RAMReq, 1); chk("t3_rrd_we", RAMWE, 0);
        RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1;
        chk("t3_rwr_we", RAMWE, 1); chk("t3_rwr_d", RAMWrD, 8'h11);
        RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1;
        chk("t3_cwr_drive", BusDrive, 1); chk("t3_cdout", CDOut, 8'h22);
        cyc(); cyc(); cyc();
        chk("t3_idle", Busy, 0);
        chk("t3_n_ca", n_ca - s_ca, 1); chk("t3_n_reua", n_reua - s_reua, 1);
        chk("t3_n_dl", n_dl - s_dl, 1); chk("t3_n_eob", n_eob - s_eob, 1);

        // 4: verify three bytes, byte 2 mismatches
        snap();
        XferType = 2'b11; Length1 = 1'b0; CD = 8'h40; RAMRdD = 8'h40; Execute = 1'b1;
        cyc(); Execute = 1'b0;
        cyc(); cyc(); RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1;
        chk("t4_b1_ca", IncCA, 1); chk("t4_b1_verr", SetVerifyErr, 0);
        chk("t4_b1_xend", XferEnd, 0);
        CD = 8'h10; RAMRdD = 8'h11;
        cyc(); cyc(); RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1;
        chk("t4_b2_verr", SetVerifyErr, 1); chk("t4_b2_xend", XferEnd, 1);
        chk("t4_b2_eob", SetEndOfBlock, 0);
        cyc(); chk("t4_end_req", RAMReq, 0); chk("t4_end_dman", DMAn, 0);
        cyc(); chk("t4_idle_dman", DMAn, 1);
        cyc(); chk("t4_no_b3", RAMReq, 0);
        chk("t4_n_ve", n_ve - s_ve, 1); chk("t4_n_ca", n_ca - s_ca, 2);

        // 4b: verify single byte with mismatch and Length1 together
        XferType = 2'b11; Length1 = 1'b1; CD = 8'h01; RAMRdD = 8'h02; Execute = 1'b1;
        cyc(); Execute = 1'b0;
        cyc(); cyc(); RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1;
        chk("t4b_verr", SetVerifyErr, 1); chk("t4b_eob", SetEndOfBlock, 1);
        chk("t4b_xend", XferEnd, 1);
        cyc(); cyc();

        // 5: reset while in R_RD
        snap();
        XferType = 2'b01; Length1 = 1'b1; Execute = 1'b1;
        cyc(); Execute = 1'b0;
        cyc(); chk("t5_rrd_req", RAMReq, 1);
        Reset = 1'b1;
        cyc(); chk("t5_dman", DMAn, 1); chk("t5_req", RAMReq, 0);
        chk("t5_busy", Busy, 0); chk("t5_rw", BusRW, 1);
        Reset = 1'b0;
        cyc(); chk("t5_still_idle", Busy, 0); chk("t5_n_xe", n_xe - s_xe, 0);

        // 6: Execute held high, XferType changed mid-transfer
        XferType = 2'b00; Length1 = 1'b1; Execute = 1'b1;
        cyc(); XferType = 2'b01;
        cyc(); chk("t6_crd_req", RAMReq, 0);
        cyc(); chk("t6_rwr_we", RAMWE, 1);
        RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0; #1; chk("t6_xend", XferEnd, 1);
        cyc(); chk("t6_end_busy", Busy, 1); chk("t6_end_req", RAMReq, 0);
        cyc(); chk("t6_idle_dman", DMAn, 1);
        cyc(); chk("t6_restart", Busy, 1);
        Execute = 1'b0;
        cyc(); chk("t6_fetch_req", RAMReq, 1); chk("t6_fetch_we", RAMWE, 0);
        RAMRdy = 1'b1;
        cyc(); RAMRdy = 1'b0;
        cyc(); cyc(); cyc();
        chk("t6_done", Busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
